// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-slot blanking gap, then one digit lit.
// Display contents change only at frame start, so a multi-digit value never tears.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IW        = $clog2(NUM_DIGITS);
    localparam int TW        = $clog2(PRESCALE);
    localparam int ON_CYCLES = PRESCALE - BLANK_CYCLES;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic [TW-1:0]           r_timer;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_v;
    logic [3:0]              r_hex;
    logic [NUM_DIGITS-1:0]   r_dig;
    logic                    r_fd;

    state_t                  w_state_n;
    logic [IW-1:0]           w_idx_n;
    logic [TW-1:0]           w_timer_n;
    logic [4*NUM_DIGITS-1:0] w_disp_n;
    logic [4*NUM_DIGITS-1:0] w_pend_n;
    logic                    w_pend_v_n;
    logic [3:0]              w_hex_n;
    logic [NUM_DIGITS-1:0]   w_dig_n;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_fd_n;
    logic                    w_slot0;

    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_timer_n  = r_timer;
        w_disp_n   = r_disp;
        w_pend_n   = r_pend;
        w_pend_v_n = r_pend_v;
        w_hex_n    = r_hex;
        w_dig_n    = DIG_OFF;
        w_onehot   = '0;
        w_fd_n     = 1'b0;
        w_slot0    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_n = S_BLANK;
                    w_idx_n   = '0;
                    w_timer_n = '0;
                    w_slot0   = 1'b1;
                end
            end
            S_BLANK: begin
                if (r_timer == TW'(BLANK_CYCLES - 1)) begin
                    w_state_n = S_ON;
                    w_timer_n = '0;
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end
            S_ON: begin
                if (r_timer == TW'(ON_CYCLES - 1)) begin
                    w_state_n = S_BLANK;
                    w_timer_n = '0;
                    if (r_idx == IW'(NUM_DIGITS - 1)) begin
                        w_idx_n = '0;
                        w_slot0 = 1'b1;
                    end else begin
                        w_idx_n = r_idx + IW'(1);
                    end
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (!en) begin
            w_state_n = S_IDLE;
            w_idx_n   = '0;
            w_timer_n = '0;
            w_slot0   = 1'b0;
        end

        if (load) begin
            w_pend_n   = digits_in;
            w_pend_v_n = 1'b1;
        end

        // Frame boundary: a coincident load bypasses pending
        if (w_slot0) begin
            if (load)
                w_disp_n = digits_in;
            else if (r_pend_v)
                w_disp_n = r_pend;
            w_pend_v_n = 1'b0;
        end else if (r_state == S_IDLE && load) begin
            w_disp_n   = digits_in;
            w_pend_v_n = 1'b0;
        end

        if (w_state_n == S_IDLE)
            w_hex_n = 4'h0;
        else if (w_state_n == S_BLANK && r_state != S_BLANK)
            w_hex_n = w_disp_n[{w_idx_n, 2'b00} +: 4];

        w_onehot[w_idx_n] = 1'b1;
        if (w_state_n == S_ON && !blank_mask[w_idx_n])
            w_dig_n = DIG_ACTIVE_LOW ? ~w_onehot : w_onehot;

        w_fd_n = (w_state_n == S_ON) &&
                 (w_idx_n == IW'(NUM_DIGITS - 1)) &&
                 (w_timer_n == TW'(ON_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_timer  <= '0;
            r_disp   <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_hex    <= 4'h0;
            r_dig    <= DIG_OFF;
            r_fd     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_idx    <= w_idx_n;
            r_timer  <= w_timer_n;
            r_disp   <= w_disp_n;
            r_pend   <= w_pend_n;
            r_pend_v <= w_pend_v_n;
            r_hex    <= w_hex_n;
            r_dig    <= w_dig_n;
            r_fd     <= w_fd_n;
        end
    end

    assign hex_out    = r_hex;
    assign dig_sel    = r_dig;
    assign frame_done = r_fd;

endmodule
